// File: rtl/rs_issue_select.sv
// Issue-select stage: picks up to three ready RS entries in round-robin order into per-lane output registers.
// Optional issue/blocked statistics counters are built when RS_ISSUE_STATS_EN is defined.
module rs_issue_select #(
    parameter int unsigned RS_SIZE   = 16,
    parameter int unsigned PAYLOAD_W = 128,
    parameter int unsigned LANES     = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [RS_SIZE-1:0]                entry_valid,
    input  logic [RS_SIZE-1:0]                entry_ready,
    input  logic [RS_SIZE*PAYLOAD_W-1:0]      entry_payload,
    input  logic                              squash,
    input  logic [LANES-1:0]                  fu_ready,
    output logic [RS_SIZE-1:0]                clear_mask,
    output logic [LANES-1:0]                  issue_valid,
    output logic [LANES*PAYLOAD_W-1:0]        issue_payload,
    output logic [LANES*$clog2(RS_SIZE)-1:0]  issue_idx,
    output logic [31:0]                       stat_issued,
    output logic [31:0]                       stat_blocked
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    logic [PAYLOAD_W-1:0] entry_pay [RS_SIZE];
    logic [RS_SIZE-1:0]   cand;
    logic [LANES-1:0]     lane_free;
    logic [LANES-1:0]     grant_lane;
    logic [1:0]           lane_of [LANES];
    logic [1:0]           n_free;
    logic [1:0]           n_grant;
    logic [IDX_W-1:0]     grant_idx [LANES];
    logic [IDX_W-1:0]     scan_idx;
    logic [IDX_W-1:0]     last_idx;

    logic [LANES-1:0]     valid_q, valid_d;
    logic [PAYLOAD_W-1:0] payload_q [LANES];
    logic [PAYLOAD_W-1:0] payload_d [LANES];
    logic [IDX_W-1:0]     idx_q [LANES];
    logic [IDX_W-1:0]     idx_d [LANES];
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

    always_comb begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            entry_pay[i] = entry_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
    end

    // Free lanes are compacted into lane_of so the k-th grant maps to the k-th free lane.
    always_comb begin
        cand      = entry_valid & entry_ready;
        lane_free = '0;
        n_free    = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            lane_of[j] = '0;
        end
        for (int unsigned j = 0; j < LANES; j++) begin
            lane_free[j] = !valid_q[j] || fu_ready[j];
            if (lane_free[j]) begin
                lane_of[n_free] = 2'(j);
                n_free          = n_free + 2'd1;
            end
        end

        grant_lane = '0;
        clear_mask = '0;
        n_grant    = '0;
        last_idx   = rr_ptr_q;
        scan_idx   = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            grant_idx[j] = '0;
        end
        if (!squash && !reset) begin
            for (int unsigned k = 0; k < RS_SIZE; k++) begin
                scan_idx = rr_ptr_q + IDX_W'(k);
                if (cand[scan_idx] && (n_grant < n_free)) begin
                    grant_lane[lane_of[n_grant]] = 1'b1;
                    grant_idx[lane_of[n_grant]]  = scan_idx;
                    clear_mask[scan_idx]         = 1'b1;
                    last_idx                     = scan_idx;
                    n_grant                      = n_grant + 2'd1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < LANES; j++) begin
            valid_d[j]   = valid_q[j];
            payload_d[j] = payload_q[j];
            idx_d[j]     = idx_q[j];
            if (squash) begin
                valid_d[j] = 1'b0;
            end else if (grant_lane[j]) begin
                valid_d[j]   = 1'b1;
                payload_d[j] = entry_pay[grant_idx[j]];
                idx_d[j]     = grant_idx[j];
            end else if (lane_free[j]) begin
                valid_d[j] = 1'b0;
            end
        end

        if (squash) begin
            rr_ptr_d = '0;
        end else if (n_grant != 2'd0) begin
            rr_ptr_d = last_idx + IDX_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            rr_ptr_q <= '0;
            for (int unsigned j = 0; j < LANES; j++) begin
                payload_q[j] <= '0;
                idx_q[j]     <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            for (int unsigned j = 0; j < LANES; j++) begin
                payload_q[j] <= payload_d[j];
                idx_q[j]     <= idx_d[j];
            end
        end
    end

    always_comb begin
        issue_valid = valid_q;
        for (int unsigned j = 0; j < LANES; j++) begin
            issue_payload[j*PAYLOAD_W +: PAYLOAD_W] = payload_q[j];
            issue_idx[j*IDX_W +: IDX_W]             = idx_q[j];
        end
    end

`ifdef RS_ISSUE_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_blocked_q, stat_blocked_d;

    always_comb begin
        stat_issued_d  = stat_issued_q + 32'(n_grant);
        stat_blocked_d = stat_blocked_q;
        if ((|cand) && (n_free == 2'd0)) begin
            stat_blocked_d = stat_blocked_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_issued_q  <= '0;
            stat_blocked_q <= '0;
        end else begin
            stat_issued_q  <= stat_issued_d;
            stat_blocked_q <= stat_blocked_d;
        end
    end

    assign stat_issued  = stat_issued_q;
    assign stat_blocked = stat_blocked_q;
`else
    assign stat_issued  = '0;
    assign stat_blocked = '0;
`endif

endmodule

// File: tb/tb_rs_issue_select.sv
// Scoreboard bench for rs_issue_select: stimulus queues per-cycle and per-lane expectations, a negedge monitor checks them.
module tb_rs_issue_select;

    localparam int RS  = 16;
    localparam int PW  = 128;
    localparam int IW  = 4;
`ifdef RS_ISSUE_STATS_EN
    localparam logic [31:0] EXP_ISS = 32'd9;
    localparam logic [31:0] EXP_BLK = 32'd2;
`else
    localparam logic [31:0] EXP_ISS = 32'd0;
    localparam logic [31:0] EXP_BLK = 32'd0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [RS-1:0]     entry_valid = '0;
    logic [RS-1:0]     entry_ready = '0;
    logic [RS*PW-1:0]  entry_payload = '0;
    logic              squash = 1'b0;
    logic [2:0]        fu_ready = '0;
    logic [RS-1:0]     clear_mask;
    logic [2:0]        issue_valid;
    logic [3*PW-1:0]   issue_payload;
    logic [3*IW-1:0]   issue_idx;
    logic [31:0]       stat_issued;
    logic [31:0]       stat_blocked;

    rs_issue_select #(.RS_SIZE(RS), .PAYLOAD_W(PW), .LANES(3)) dut (
        .clock(clock), .reset(reset),
        .entry_valid(entry_valid), .entry_ready(entry_ready), .entry_payload(entry_payload),
        .squash(squash), .fu_ready(fu_ready), .clear_mask(clear_mask),
        .issue_valid(issue_valid), .issue_payload(issue_payload), .issue_idx(issue_idx),
        .stat_issued(stat_issued), .stat_blocked(stat_blocked)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] clr;
        logic [2:0]  vld;
        bit          cs;
        logic [31:0] iss;
        logic [31:0] blk;
    } cyc_exp_t;

    typedef struct {
        int          idx;
        logic [127:0] pay;
    } lane_exp_t;

    cyc_exp_t  cyc_q[$];
    lane_exp_t lane_q[3][$];
    int checks = 0;
    int errors = 0;
    logic [31:0] salt = 32'h1000;

    function automatic logic [127:0] pay(input int i, input logic [31:0] s);
        return {s, 32'(i), s ^ 32'hDEADBEEF ^ 32'(i), 32'hA5A50000 | 32'(i)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        cyc_exp_t  e;
        lane_exp_t l;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("clear_mask", 128'(clear_mask), 128'(e.clr));
            chk("issue_valid", 128'(issue_valid), 128'(e.vld));
            if (e.cs) begin
                chk("stat_issued", 128'(stat_issued), 128'(e.iss));
                chk("stat_blocked", 128'(stat_blocked), 128'(e.blk));
            end
        end
        for (int j = 0; j < 3; j++) begin
            if (!reset && issue_valid[j] && fu_ready[j]) begin
                if (lane_q[j].size() == 0) begin
                    chk($sformatf("unexpected_xfer_lane%0d", j), 128'(issue_idx[j*IW +: IW]), 128'hFFFF);
                end else begin
                    l = lane_q[j].pop_front();
                    chk($sformatf("idx_lane%0d", j), 128'(issue_idx[j*IW +: IW]), 128'(l.idx));
                    chk($sformatf("payload_lane%0d", j), issue_payload[j*PW +: PW], l.pay);
                end
            end
        end
    end

    task automatic grant(input int lane, input int idx);
        lane_exp_t l;
        l.idx = idx;
        l.pay = pay(idx, salt);
        lane_q[lane].push_back(l);
    endtask

    // Drives one cycle of inputs and queues what the monitor should see in that same cycle.
    task automatic cyc(input logic [15:0] c, input logic [2:0] fr, input logic sq,
                       input logic [15:0] eclr, input logic [2:0] ev,
                       input bit cs = 1'b0, input logic [31:0] ei = '0, input logic [31:0] eb = '0);
        cyc_exp_t e;
        entry_valid = c | (~c & 16'hA0A0);
        entry_ready = c | (~c & 16'h0A0A);
        for (int i = 0; i < RS; i++) entry_payload[i*PW +: PW] = pay(i, salt);
        fu_ready = fr;
        squash   = sq;
        e.clr = eclr; e.vld = ev; e.cs = cs; e.iss = ei; e.blk = eb;
        cyc_q.push_back(e);
        @(posedge clock);
        #1;
        salt = salt + 32'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int j = 0; j < 3; j++) lane_q[j].delete();
        cyc(16'hFFFF, 3'b000, 1'b0, 16'h0000, 3'b000, 1'b1, 32'd0, 32'd0);
        cyc(16'hFFFF, 3'b000, 1'b0, 16'h0000, 3'b000, 1'b1, 32'd0, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(posedge clock);
        #1;

        // Reset and idle; pointer still 0 afterwards
        do_reset();
        cyc(16'h0000, 3'b111, 1'b0, 16'h0000, 3'b000);
        cyc(16'h0000, 3'b111, 1'b0, 16'h0000, 3'b000);
        grant(0, 0); grant(1, 15);
        cyc(16'h8001, 3'b111, 1'b0, 16'h8001, 3'b000);
        cyc(16'h0000, 3'b111, 1'b0, 16'h0000, 3'b011);
        cyc(16'h0000, 3'b111, 1'b0, 16'h0000, 3'b000);

        // Full issue
        do_reset();
        grant(0, 3); grant(1, 5); grant(2, 9);
        cyc(16'h1228, 3'b111, 1'b0, 16'h0228, 3'b000);
        grant(0, 12); grant(1, 1);
        cyc(16'h1002, 3'b111, 1'b0, 16'h1002, 3'b111);
        cyc(16'h0000, 3'b111, 1'b0, 16'h0000, 3'b011);
        cyc(16'h0000, 3'b111, 1'b0, 16'h0000, 3'b000);

        // Wrap-around, then reset lands while lane0 is still loaded
        do_reset();
        grant(0, 13);
        cyc(16'h2000, 3'b111, 1'b0, 16'h2000, 3'b000);
        grant(0, 15); grant(1, 0); grant(2, 1);
        cyc(16'h8007, 3'b111, 1'b0, 16'h8003, 3'b001);
        grant(0, 2); grant(1, 3); grant(2, 4);
        cyc(16'h001E, 3'b111, 1'b0, 16'h001C, 3'b111);
        grant(0, 6);
        cyc(16'h0040, 3'b111, 1'b0, 16'h0040, 3'b111);
        cyc(16'h0000, 3'b000, 1'b0, 16'h0000, 3'b001);

        // Backpressure on lane1
        do_reset();
        grant(0, 7); grant(1, 8);
        cyc(16'h0180, 3'b111, 1'b0, 16'h0180, 3'b000);
        grant(0, 4); grant(2, 6);
        cyc(16'h0050, 3'b101, 1'b0, 16'h0050, 3'b011);
        cyc(16'h0000, 3'b111, 1'b0, 16'h0000, 3'b111);
        cyc(16'h0000, 3'b111, 1'b0, 16'h0000, 3'b000);

        // Squash beats grant, pointer returns to 0
        do_reset();
        grant(0, 0); grant(1, 1);
        cyc(16'h0003, 3'b111, 1'b0, 16'h0003, 3'b000);
        cyc(16'h000C, 3'b000, 1'b1, 16'h0000, 3'b011);
        for (int j = 0; j < 3; j++) lane_q[j].delete();
        grant(0, 1); grant(1, 4);
        cyc(16'h0012, 3'b111, 1'b0, 16'h0012, 3'b000);
        cyc(16'h0000, 3'b111, 1'b0, 16'h0000, 3'b011);
        cyc(16'h0000, 3'b111, 1'b0, 16'h0000, 3'b000);

        // Statistics
        do_reset();
        grant(0, 0); grant(1, 1); grant(2, 2);
        cyc(16'h0007, 3'b111, 1'b0, 16'h0007, 3'b000);
        grant(0, 3); grant(1, 4); grant(2, 5);
        cyc(16'h0038, 3'b111, 1'b0, 16'h0038, 3'b111);
        grant(0, 6); grant(1, 7); grant(2, 8);
        cyc(16'h01C0, 3'b111, 1'b0, 16'h01C0, 3'b111);
        cyc(16'h0600, 3'b000, 1'b0, 16'h0000, 3'b111);
        cyc(16'h0600, 3'b000, 1'b0, 16'h0000, 3'b111);
        cyc(16'h0000, 3'b111, 1'b0, 16'h0000, 3'b111, 1'b1, EXP_ISS, EXP_BLK);
        cyc(16'h0000, 3'b111, 1'b0, 16'h0000, 3'b000, 1'b1, EXP_ISS, EXP_BLK);

        for (int j = 0; j < 3; j++) begin
            chk($sformatf("lane%0d_pending", j), 128'(lane_q[j].size()), 128'd0);
        end
        chk("cycle_pending", 128'(cyc_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_issue_select.md
# rs_issue_select

Issue-select stage directly downstream of the reservation station (RS). Each cycle it picks up to three RS entries whose operands are both ready, using a round-robin start pointer. It returns a clear mask so the RS frees those entries, and latches the selected payloads into three per-lane output registers. The registers hand off to the functional units over a valid/ready handshake.

## Interface
Parameters:
- `RS_SIZE`, default 16: number of RS entries; power of two, index width `$clog2(RS_SIZE)`.
- `PAYLOAD_W`, default 128: width of the opaque per-entry payload (RS packet bits).
- `LANES`, default 3: issue width; fixed at 3 for this block.

Ports (clock and reset are the single clock and an asynchronous, active-high reset):
- `clock` in 1: sole clock, posedge.
- `reset` in 1: asynchronous, active-high.
- `entry_valid` in RS_SIZE: RS entry i occupied.
- `entry_ready` in RS_SIZE: entry i has both operands ready; ignored where `entry_valid[i]`=0.
- `entry_payload` in RS_SIZE×PAYLOAD_W: payload of entry i.
- `squash` in 1: synchronous flush (branch mispredict).
- `fu_ready` in 3: FU lane j accepts this cycle.
- `clear_mask` out RS_SIZE: combinational; RS invalidates entry i at the next posedge.
- `issue_valid` out 3: output register lane j holds an instruction.
- `issue_payload` out 3×PAYLOAD_W: registered payload per lane.
- `issue_idx` out 3×$clog2(RS_SIZE): RS index the lane payload came from (debug).
- `stat_issued` out 32: total instructions issued (see Configuration).
- `stat_blocked` out 32: blocked-cycle count (see Configuration).

## Operation
- Lane j is free when `!issue_valid[j] || fu_ready[j]`. A transfer occurs when `issue_valid[j] && fu_ready[j]`. F = number of free lanes (0–3).
- Candidate set: `entry_valid & entry_ready`.
- Scan order: `rr_ptr, rr_ptr+1, …`, wrapping mod RS_SIZE. The first min(F, #candidates) candidates in that order are granted.
- Grant k (in scan order) goes to the k-th free lane, lowest lane index first.
- `clear_mask[i]`=1 exactly for granted entries. It never has more than F bits set.
- At the posedge, each granted lane loads payload and index and sets `issue_valid`. A free lane with no grant clears `issue_valid`. A non-free lane holds its contents.
- Pointer update: `rr_ptr <= (last granted index + 1) mod RS_SIZE`. With no grant, `rr_ptr` holds.
- `squash`=1 takes priority over everything else:
  - `clear_mask` = 0 that cycle.
  - All `issue_valid` are cleared at the posedge.
  - `rr_ptr` is set to 0.
  - Payload registers keep stale data.
- A held lane (valid and `!fu_ready`) is never overwritten. Backpressure on one lane does not block the other lanes.

## Timing
- Select is combinational from inputs in cycle t; the issued instruction appears on `issue_*` at cycle t+1. Latency: 1 cycle.
- `clear_mask` is asserted in the same cycle as the grant. The RS must drop the entry at that same posedge, so the entry is never granted twice.
- Back-to-back issue on one lane is allowed when `fu_ready` is held high: sustained 3 instructions per cycle.
- Reset values: `issue_valid`=0, `issue_payload`=0, `issue_idx`=0, `rr_ptr`=0, `stat_*`=0. `clear_mask` is 0 while reset is asserted.
- Reset asserted mid-operation discards all lanes immediately, without waiting for a clock edge.
- RS_SIZE=16 wrap example: with `rr_ptr`=14 and candidates {15,0,1,2}, the grants are 15→lane0, 0→lane1, 1→lane2, and the new `rr_ptr` is 2.

## Configuration
- `RS_ISSUE_STATS_EN` defined:
  - `stat_issued` increments by the number of grants each non-squash cycle, wrapping at 2^32.
  - `stat_blocked` increments by 1 in each cycle where candidates exist but F=0.
- `RS_ISSUE_STATS_EN` undefined:
  - The counters are not built.
  - `stat_issued` and `stat_blocked` are tied to 0; the ports remain for interface stability.

## Test plan
- **Reset and idle:** hold reset, then release with no candidates. `issue_valid`=000, `clear_mask`=0, and `rr_ptr` stays 0.
- **Full issue:** `rr_ptr`=0, candidates {3,5,9,12}, `fu_ready`=111. Expect `clear_mask`=0x0228; next cycle `issue_idx`={9,5,3} on lanes 2/1/0 and `rr_ptr`=10; the following cycle 12 issues on lane0.
- **Wrap-around:** `rr_ptr`=14, candidates {15,0,1,2}. Expect grants 15/0/1 on lanes 0/1/2, `rr_ptr`=2, and entry 2 issued the next cycle.
- **Backpressure:** lane1 valid with `fu_ready`=101, candidates {4,6}. Expect 4→lane0 and 6→lane2; lane1 payload unchanged; `clear_mask`=0x0050.
- **Squash vs grant:** candidates present and `squash`=1. Expect `clear_mask`=0, all lanes invalid next cycle, and `rr_ptr`=0.
- **Stats (macro on):** 3 cycles issuing 3 each, then 2 cycles with `fu_ready`=000 and candidates present. Expect `stat_issued`=9 and `stat_blocked`=2; with the macro off, both stay 0.
